ram_dual_port_be: RTL and testbench

Parametrised simple dual-port RAM: one write port with byte enables, one read port, single clock. It generalises the fixed 8-bit, 1-cycle scratch RAM with four additions: selectable read-during-write behaviour, an optional output register stage, a valid strobe, and a hardware clear sequencer that fills the array with a constant after reset or on request. It serves as the generic buffer and lookup memory behind the SPI/AHB peripherals and the MIPSfpga glue logic.

---
 rtl/ram_pkg.sv | 37 +++
 rtl/ram_sweep_ctrl.sv | 62 ++++++
 rtl/ram_dual_port_be.sv | 115 +++++++++++
 tb/tb_ram_dual_port_be.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// ram_pkg : shared constants, sweep FSM states and byte-lane merge helper
// Revision: 1.0
// ============================================================================
package ram_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  localparam bit RDW_OLD = 1'b0;
  localparam bit RDW_NEW = 1'b1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned BE_MAX_W = 1024;
  localparam int unsigned BE_MAX_B = BE_MAX_W / 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

  function automatic logic [BE_MAX_W-1:0] be_merge(
    input logic [BE_MAX_W-1:0] old_w,
    input logic [BE_MAX_W-1:0] new_w,
    input logic [BE_MAX_B-1:0] be
  );
    logic [BE_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_MAX_B; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// ram_sweep_ctrl : IDLE/SWEEP controller and clear-address counter
// Revision: 1.0
// ============================================================================
module ram_sweep_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  output logic                  sweep_we,
  output logic [ADDR_WIDTH-1:0] sweep_addr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam sweep_state_e          RESET_STATE = sweep_state_e'(CLEAR_ON_RESET);

  sweep_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sweep_we   = 1'b0;
    sweep_addr = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        sweep_we = 1'b1;
        // A restart writes address 0 in the same cycle it is requested.
        if (clear) sweep_addr = '0;
        if (sweep_addr == LAST_ADDR) state_d = ST_IDLE;
        cnt_d = sweep_addr + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/ram_dual_port_be.sv
`default_nettype none
// ============================================================================
// ram_dual_port_be : simple dual-port byte-enable RAM with clear sweep
// Revision: 1.0
// ============================================================================
module ram_dual_port_be #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 6,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter bit                    RDW_NEW        = 1'b0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter string                 INIT_FILE      = ""
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    q_valid,
  output logic                    ready
);

  import ram_pkg::*;

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  w_sweep_we;
  logic [ADDR_WIDTH-1:0] w_sweep_addr;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic [DATA_WIDTH-1:0] rd1_data_q;
  logic                  rd1_valid_q;

  ram_sweep_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_sweep (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .sweep_we   (w_sweep_we),
    .sweep_addr (w_sweep_addr),
    .ready      (ready)
  );

  always_comb begin
    w_wr_fire   = wr_en & ready;
    w_rd_fire   = rd_en & ready;
    w_wr_merged = DATA_WIDTH'(be_merge(BE_MAX_W'(mem[wr_addr]),
                                       BE_MAX_W'(wr_data),
                                       BE_MAX_B'(wr_be)));
    w_rd_word   = mem[rd_addr];
    // Same-address bypass: the merged word equals what the array will hold.
    if ((RDW_NEW == ram_pkg::RDW_NEW) && w_wr_fire && (wr_addr == rd_addr)) begin
      w_rd_word = w_wr_merged;
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      mem[w_sweep_addr] <= CLEAR_VALUE;
    end else if (w_wr_fire) begin
      mem[wr_addr] <= w_wr_merged;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd1_data_q  <= '0;
      rd1_valid_q <= 1'b0;
    end else begin
      rd1_valid_q <= w_rd_fire;
      if (w_rd_fire) rd1_data_q <= w_rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd2_data_q;
    logic                  rd2_valid_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd2_data_q  <= '0;
        rd2_valid_q <= 1'b0;
      end else begin
        rd2_valid_q <= rd1_valid_q;
        if (rd1_valid_q) rd2_data_q <= rd1_data_q;
      end
    end

    assign q       = rd2_data_q;
    assign q_valid = rd2_valid_q;
  end else begin : g_lat1
    assign q       = rd1_data_q;
    assign q_valid = rd1_valid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_dual_port_be.sv
`default_nettype none
// ============================================================================
// tb_ram_dual_port_be : two configurations (old-data/1-cycle, new-data/2-cycle)
// Revision: 1.0
// ============================================================================
module tb_ram_dual_port_be;

  localparam int          DEPTH = 64;
  localparam logic [31:0] CLR   = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        clear = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [5:0]  rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] q0, q1;
  logic        v0, v1, rdy0, rdy1;

  always #5 clk = ~clk;

  ram_dual_port_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(1), .RDW_NEW(1'b0),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR), .INIT_FILE("")
  ) dut0 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .clear(clear),
    .q(q0), .q_valid(v0), .ready(rdy0)
  );

  ram_dual_port_be #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(2), .RDW_NEW(1'b1),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .clear(clear),
    .q(q1), .q_valid(v1), .ready(rdy1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  int          sweep_left;
  int          sweep_pos;
  logic [31:0] e0_q, s1_q, e1_q;
  bit          e0_v, s1_v, e1_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    sweep_left = DEPTH;
    sweep_pos  = 0;
    e0_q = '0; e0_v = 1'b0;
    s1_q = '0; s1_v = 1'b0;
    e1_q = '0; e1_v = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] rd_old, rd_new;
    bit          served;
    served = 1'b0;
    rd_old = '0;
    rd_new = '0;
    e1_v = s1_v;
    if (s1_v) e1_q = s1_q;
    if (sweep_left == 0) begin
      if (rd_en) begin
        served = 1'b1;
        rd_old = mem_m[rd_addr];
        rd_new = (wr_en && wr_addr == rd_addr) ? merge(rd_old, wr_data, wr_be) : rd_old;
      end
      if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
      if (clear) begin sweep_pos = 0; sweep_left = DEPTH; end
    end else begin
      if (clear) begin sweep_pos = 0; sweep_left = DEPTH; end
      mem_m[sweep_pos] = CLR;
      sweep_pos++;
      sweep_left--;
    end
    e0_v = served;
    if (served) e0_q = rd_old;
    s1_v = served;
    if (served) s1_q = rd_new;
  endtask

  task automatic check_outputs();
    check_eq("q_lat1", q0, e0_q);
    check_eq("qvalid_lat1", {31'b0, v0}, {31'b0, e0_v});
    check_eq("q_lat2", q1, e1_q);
    check_eq("qvalid_lat2", {31'b0, v1}, {31'b0, e1_v});
    check_eq("ready0", {31'b0, rdy0}, {31'b0, sweep_left == 0});
    check_eq("ready1", {31'b0, rdy1}, {31'b0, sweep_left == 0});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Counts cycles until ready returns, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!rdy0 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic read_expect(input string tag, input logic [5:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check_eq(tag, q0, exp);
    tick();
    check_eq(tag, q1, exp);
  endtask

  int n;

  initial begin
    model_reset();
    repeat (3) tick();

    // Reset sweep
    resetn = 1'b1;
    wait_ready(n);
    check_eq("reset_sweep_len", n, 64);
    read_expect("sweep_rd0", 6'd0, CLR);
    read_expect("sweep_rd31", 6'd31, CLR);
    read_expect("sweep_rd63", 6'd63, CLR);

    // Byte enables
    do_write(6'd5, 32'h11223344, 4'hF);
    do_write(6'd5, 32'hAABBCCDD, 4'b0101);
    do_write(6'd5, 32'h99999999, 4'b0000);
    read_expect("byte_enable", 6'd5, 32'h11BB33DD);

    // Read-during-write
    do_write(6'd9, 32'h0, 4'hF);
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'hFFFF_FFFF; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 6'd9;
    tick();
    idle_inputs();
    check_eq("rdw_old", q0, 32'h0);
    tick();
    check_eq("rdw_new", q1, 32'h0000FFFF);

    // Latency-2 back-to-back
    for (int i = 1; i <= 3; i++) do_write(6'(i), 32'(i), 4'hF);
    rd_en = 1'b1; rd_addr = 6'd1; tick();
    rd_addr = 6'd2; tick();
    check_eq("lat2_first", q1, 32'd1);
    check_eq("lat2_first_v", {31'b0, v1}, 32'd1);
    rd_addr = 6'd3; tick();
    check_eq("lat2_second", q1, 32'd2);
    rd_en = 1'b0; tick();
    check_eq("lat2_third", q1, 32'd3);
    tick();
    check_eq("lat2_done_v", {31'b0, v1}, 32'd0);

    // Clear during streaming reads; writes in SWEEP are dropped
    rd_en = 1'b1; rd_addr = 6'd3; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'h12345678; wr_be = 4'hF;
      rd_addr = 6'(i);
      tick();
    end
    idle_inputs();
    wait_ready(n);
    read_expect("clear_drops_write", 6'd7, CLR);

    // Second clear at counter 20 restarts the sweep
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (20) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    wait_ready(n);
    check_eq("restart_sweep_len", n + 21, 84);

    // Reset mid-read
    do_write(6'd11, 32'hCAFEF00D, 4'hF);
    rd_en = 1'b1; rd_addr = 6'd11; tick(); tick();
    rd_en = 1'b0;
    resetn = 1'b0;
    #1;
    model_reset();
    check_eq("rst_read_v0", {31'b0, v0}, 32'd0);
    check_eq("rst_read_v1", {31'b0, v1}, 32'd0);
    check_eq("rst_read_q0", q0, 32'd0);
    check_eq("rst_read_rdy", {31'b0, rdy0}, 32'd0);
    tick();
    resetn = 1'b1;
    wait_ready(n);
    check_eq("rst_read_sweep_len", n, 64);

    // Reset mid-sweep at counter 30
    do_write(6'd40, 32'h0BADC0DE, 4'hF);
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (30) tick();
    resetn = 1'b0;
    #1;
    model_reset();
    check_eq("rst_sweep_v", {31'b0, v0 | v1}, 32'd0);
    check_eq("rst_sweep_rdy", {31'b0, rdy0 | rdy1}, 32'd0);
    tick();
    resetn = 1'b1;
    wait_ready(n);
    check_eq("rst_sweep_len", n, 64);
    read_expect("rst_sweep_rd40", 6'd40, CLR);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom % 2) == 0;
      wr_addr = 6'($urandom_range(0, 63));
      wr_be   = 4'($urandom);
      wr_data = $urandom;
      rd_en   = ($urandom % 4) != 0;
      rd_addr = (($urandom % 3) == 0) ? wr_addr : 6'($urandom_range(0, 63));
      clear   = ($urandom % 150) == 0;
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
